// File: rtl/instr_fetch_seq_pkg.sv
// Shared ISA constants, fetch state encodings and instruction decode helpers
// for the riscv_mini instruction fetch sequencer.
package instr_fetch_seq_pkg;

   localparam int          WIDTH     = 16;
   localparam logic [15:0] NOP_INSTR = 16'h0003;
   localparam logic [1:0]  OP_OUT    = 2'b11;
   localparam logic [2:0]  F3_CMP    = 3'b011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_HALT = 2'd3
   } fetch_state_t;

   // A compare whose true result makes the core skip the following instruction.
   function automatic logic is_cmp(input logic [WIDTH-1:0] instr);
      return (instr[1:0] == OP_OUT) && (instr[15:13] == F3_CMP);
   endfunction

endpackage

// File: rtl/instr_fetch_seq_mem.sv
// Instruction store: flop array with a synchronous write port and an
// asynchronous read port so the fetch can issue in the same cycle it decides.
module instr_fetch_seq_mem #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int IW    = 16
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [IW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [IW-1:0] rdata
);

   logic [IW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_seq.sv
// Byte-serial program loader and one-instruction-per-clock fetch sequencer
// with compare-driven skip, pause/resume and single-shot or looping execution.
module instr_fetch_seq
   import instr_fetch_seq_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH),
   parameter int IW    = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_en,
   input  logic [7:0]    wr_byte,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic          run,
   input  logic          loop,
   input  logic          cond_in,
   output logic [IW-1:0] instr_out,
   output logic          instr_valid,
   output logic [AW-1:0] pc_out,
   output logic [AW:0]   prog_len,
   output logic          done
);

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   fetch_state_t  state;
   logic          phase_hi;
   logic [7:0]    hold;
   logic [AW:0]   pc;
   logic [AW:0]   nxt_raw, nxt_wrap, nxt;
   logic          skip, at_end, xfer, mem_we;
   logic [IW-1:0] rd_data;

   always_comb begin
      skip     = instr_valid && is_cmp(instr_out) && cond_in;
      nxt_raw  = pc + {{AW{1'b0}}, skip};
      at_end   = (nxt_raw >= prog_len);
      // A skip past the last entry can overshoot by two; fold a second time
      // so a one-entry program still lands inside the store.
      nxt_wrap = nxt_raw - prog_len;
      if (nxt_wrap >= prog_len) nxt_wrap = nxt_wrap - prog_len;
      nxt      = at_end ? nxt_wrap : nxt_raw;
      wr_ready = (state == ST_LOAD) && (prog_len < FULL);
      xfer     = wr_valid && wr_ready;
      mem_we   = xfer && phase_hi;
      done     = (state == ST_HALT);
   end

   instr_fetch_seq_mem #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (prog_len[AW-1:0]),
      .wdata ({wr_byte, hold}),
      .raddr (nxt[AW-1:0]),
      .rdata (rd_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         instr_out   <= NOP_INSTR;
         instr_valid <= 1'b0;
         pc          <= '0;
         pc_out      <= '0;
         prog_len    <= '0;
         phase_hi    <= 1'b0;
         hold        <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (load_en) begin
                  state    <= ST_LOAD;
                  prog_len <= '0;
                  phase_hi <= 1'b0;
               end else if (run && prog_len != '0) begin
                  state <= ST_RUN;
               end
            end
            ST_LOAD: begin
               if (xfer) begin
                  if (!phase_hi) begin
                     hold     <= wr_byte;
                     phase_hi <= 1'b1;
                  end else begin
                     phase_hi <= 1'b0;
                     prog_len <= prog_len + 1'b1;
                  end
               end
               // Leaving load drops any half-assembled instruction.
               if (!load_en) begin
                  state    <= ST_IDLE;
                  pc       <= '0;
                  phase_hi <= 1'b0;
               end
            end
            ST_RUN: begin
               if (!run) begin
                  state       <= ST_IDLE;
                  pc          <= nxt_raw;
                  instr_out   <= NOP_INSTR;
                  instr_valid <= 1'b0;
               end else if (at_end && !loop) begin
                  state       <= ST_HALT;
                  instr_out   <= NOP_INSTR;
                  instr_valid <= 1'b0;
               end else begin
                  instr_out   <= rd_data;
                  pc_out      <= nxt[AW-1:0];
                  instr_valid <= 1'b1;
                  pc          <= nxt + 1'b1;
               end
            end
            ST_HALT: begin
               if (!run) begin
                  state <= ST_IDLE;
                  pc    <= '0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Self-checking bench: table of load/run scenarios checked through an issue
// scoreboard, plus hand-written overfill, pause, abort and reset sequences.
module tb_instr_fetch_seq;

   logic        clk = 1'b0;
   logic        rst_n, load_en, wr_valid, run, loop, cond_in;
   logic [7:0]  wr_byte;
   logic        wr_ready, instr_valid, done;
   logic [15:0] instr_out;
   logic [3:0]  pc_out;
   logic [4:0]  prog_len;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [15:0] instr;
      logic [3:0]  pc;
   } exp_t;

   typedef struct {
      logic [3:0][15:0] prog;
      int               len;
      logic             lp;
      logic             cnd;
      int               n;
      logic [31:0]      pcs;   // expected issue pcs, one nibble each, first in bits [3:0]
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[7];

   instr_fetch_seq dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_en     (load_en),
      .wr_byte     (wr_byte),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .run         (run),
      .loop        (loop),
      .cond_in     (cond_in),
      .instr_out   (instr_out),
      .instr_valid (instr_valid),
      .pc_out      (pc_out),
      .prog_len    (prog_len),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mkv(input int len, input logic [15:0] a, b, c, d,
                                input logic lp, cnd, input int n, input logic [31:0] pcs);
      vec_t v;
      v.prog = {d, c, b, a};
      v.len  = len;
      v.lp   = lp;
      v.cnd  = cnd;
      v.n    = n;
      v.pcs  = pcs;
      return v;
   endfunction

   task automatic do_reset;
      rst_n = 1'b0; load_en = 1'b0; wr_valid = 1'b0; wr_byte = '0;
      run = 1'b0; loop = 1'b0; cond_in = 1'b0;
      tick;
      rst_n = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      wr_byte  = b;
      wr_valid = 1'b1;
      tick;
   endtask

   task automatic load_prog(input logic [3:0][15:0] p, input int len);
      load_en = 1'b1;
      tick;
      for (int i = 0; i < len; i++) begin
         send_byte(p[i][7:0]);
         send_byte(p[i][15:8]);
      end
      wr_valid = 1'b0;
      load_en  = 1'b0;
      tick;
      chk("load_prog_len", 32'(prog_len), 32'(len));
   endtask

   // Runs until every queued issue has been seen, then checks how it stops.
   task automatic drain(input logic lp);
      exp_t e;
      int   budget = 0;
      run  = 1'b1;
      loop = lp;
      while (exp_q.size() != 0 && budget < 80) begin
         tick;
         budget++;
         if (instr_valid) begin
            e = exp_q.pop_front();
            chk("issue_instr", 32'(instr_out), 32'(e.instr));
            chk("issue_pc", 32'(pc_out), 32'(e.pc));
            if (exp_q.size() == 0 && lp) run = 1'b0;
         end
      end
      chk("drain_left", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      if (!lp) begin
         tick;
         chk("halt_done", 32'(done), 32'd1);
         chk("halt_valid", 32'(instr_valid), 32'd0);
         chk("halt_nop", 32'(instr_out), 32'h0003);
      end
      run = 1'b0;
      tick;
      chk("stop_valid", 32'(instr_valid), 32'd0);
      chk("stop_done", 32'(done), 32'd0);
   endtask

   task automatic wait_pc(input logic [3:0] want, input string name);
      int budget = 0;
      while (!(instr_valid && pc_out == want) && budget < 40) begin
         tick;
         budget++;
      end
      chk(name, 32'(pc_out), 32'(want));
   endtask

   initial begin
      exp_t e;
      vecs[0] = mkv(3, 16'h0013, 16'h6023, 16'h0003, 16'h0003, 1'b0, 1'b0, 3, 32'h0000_0210);
      vecs[1] = mkv(4, 16'h6003, 16'h1013, 16'h2013, 16'h3013, 1'b0, 1'b1, 3, 32'h0000_0320);
      vecs[2] = mkv(4, 16'h6003, 16'h1013, 16'h2013, 16'h3013, 1'b0, 1'b0, 4, 32'h0000_3210);
      vecs[3] = mkv(3, 16'h0013, 16'h6003, 16'h0093, 16'h0003, 1'b1, 1'b1, 6, 32'h0010_1010);
      vecs[4] = mkv(3, 16'h0013, 16'h0113, 16'h0213, 16'h0003, 1'b1, 1'b0, 6, 32'h0021_0210);
      vecs[5] = mkv(2, 16'h0013, 16'h6003, 16'h0003, 16'h0003, 1'b0, 1'b1, 2, 32'h0000_0010);
      vecs[6] = mkv(3, 16'h6003, 16'h0113, 16'h0213, 16'h0003, 1'b1, 1'b1, 4, 32'h0000_2020);

      do_reset;
      chk("rst_instr", 32'(instr_out), 32'h0003);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_pc", 32'(pc_out), 32'd0);
      chk("rst_len", 32'(prog_len), 32'd0);
      chk("rst_ready", 32'(wr_ready), 32'd0);
      chk("rst_done", 32'(done), 32'd0);

      for (int v = 0; v < 7; v++) begin
         do_reset;
         load_prog(vecs[v].prog, vecs[v].len);
         cond_in = vecs[v].cnd;
         for (int i = 0; i < vecs[v].n; i++) begin
            e.pc    = vecs[v].pcs[4*i +: 4];
            e.instr = vecs[v].prog[e.pc[1:0]];
            exp_q.push_back(e);
         end
         drain(vecs[v].lp);
      end

      // Overfill: 17 instructions offered, only 16 fit.
      do_reset;
      load_en = 1'b1;
      tick;
      for (int i = 0; i < 34; i++) begin
         if (i == 0 || i == 31) chk("full_ready_hi", 32'(wr_ready), 32'd1);
         if (i >= 32) chk("full_ready_lo", 32'(wr_ready), 32'd0);
         send_byte((i % 2 == 0) ? 8'h13 : ((i < 32) ? 8'(i / 2) : 8'hAA));
      end
      wr_valid = 1'b0;
      chk("full_len", 32'(prog_len), 32'd16);
      load_en = 1'b0;
      tick;
      for (int k = 0; k < 16; k++) begin
         e.instr = {8'(k), 8'h13};
         e.pc    = 4'(k);
         exp_q.push_back(e);
      end
      drain(1'b0);

      // Pause after pc 1, resume at pc 2.
      do_reset;
      load_prog({16'h0313, 16'h0213, 16'h0113, 16'h0013}, 4);
      run = 1'b1;
      wait_pc(4'd1, "pause_reach");
      run = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("pause_valid", 32'(instr_valid), 32'd0);
         chk("pause_nop", 32'(instr_out), 32'h0003);
      end
      run = 1'b1;
      wait_pc(4'd2, "resume_pc");
      chk("resume_instr", 32'(instr_out), 32'h0213);

      // Pause while a true compare is on the output: skip still applies.
      do_reset;
      load_prog({16'h3013, 16'h2013, 16'h1013, 16'h6003}, 4);
      cond_in = 1'b1;
      run = 1'b1;
      wait_pc(4'd0, "pskip_reach");
      run = 1'b0;
      tick;
      chk("pskip_valid", 32'(instr_valid), 32'd0);
      run = 1'b1;
      wait_pc(4'd2, "pskip_resume");
      chk("pskip_instr", 32'(instr_out), 32'h2013);

      // Load aborted after one byte: nothing loaded, run stays idle.
      do_reset;
      load_en = 1'b1;
      tick;
      send_byte(8'h13);
      wr_valid = 1'b0;
      load_en  = 1'b0;
      tick;
      chk("abort_len", 32'(prog_len), 32'd0);
      run = 1'b1;
      tick; tick; tick;
      chk("abort_valid", 32'(instr_valid), 32'd0);
      run = 1'b0;

      // Reset in the middle of a run.
      do_reset;
      load_prog({16'h0003, 16'h0003, 16'h0113, 16'h0013}, 2);
      run  = 1'b1;
      loop = 1'b1;
      wait_pc(4'd1, "rrun_reach");
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      chk("rrun_instr", 32'(instr_out), 32'h0003);
      chk("rrun_valid", 32'(instr_valid), 32'd0);
      chk("rrun_len", 32'(prog_len), 32'd0);
      tick; tick;
      chk("rrun_idle", 32'(instr_valid), 32'd0);
      run = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
